// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA state encoding and the bus addresses
// the controller decodes and drives.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite (OAM) DMA engine: a CPU write to $4014 stalls the CPU and copies
// the 256 bytes of page $XX00-$XXFF into the PPU OAMDATA port one by one.
module oam_dma_controller
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [15:0] cpuAddr,
  input  logic        cpuWrite,
  input  logic [7:0]  cpuData_IN,
  input  logic [7:0]  busData_IN,
  output logic        cpuHalt,
  output logic [15:0] dmaAddr,
  output logic        dmaReadWrite,
  output logic [7:0]  dmaData_OUT,
  output logic        oamData_EN,
  output logic        busy
);

  dma_state_t state_q, state_d;
  logic [7:0] page_q;
  logic [7:0] counter_q;
  logic [7:0] data_q;
  logic       parity_q;
  logic       trigger;

  assign trigger = (state_q == IDLE) && cpuWrite && (cpuAddr == OAMDMA_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      page_q    <= '0;
      counter_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
    end else if (clkEn) begin
      parity_q <= ~parity_q;
      state_q  <= state_d;
      if (trigger) begin
        page_q    <= cpuData_IN;
        counter_q <= '0;
      end
      if (state_q == READ) begin
        data_q <= busData_IN;
      end
      if (state_q == WRITE) begin
        counter_q <= counter_q + 8'd1;
      end
    end
  end

  // NOTE: every output and next-state value gets a default first so no path
  // through the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cpuHalt      = 1'b1;
    busy         = 1'b1;
    dmaAddr      = '0;
    dmaReadWrite = 1'b1;
    dmaData_OUT  = '0;
    oamData_EN   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpuHalt = 1'b0;
        busy    = 1'b0;
        if (trigger) state_d = HALT;
      end
      // Reads must land on the cycle whose parity will be 0; parity flips at
      // the end of this cycle, so a current parity of 1 means we are aligned.
      HALT: begin
        state_d = parity_q ? READ : ALIGN;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        dmaAddr = {page_q, counter_q};
        state_d = WRITE;
      end
      WRITE: begin
        dmaAddr      = OAMDATA_ADDR;
        dmaReadWrite = 1'b0;
        dmaData_OUT  = data_q;
        oamData_EN   = 1'b1;
        state_d      = (counter_q == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for the OAM DMA controller: parity alignment, stall length,
// ignored re-trigger, asynchronous reset mid-transfer and clkEn stalls.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn = 1'b0;
  logic [15:0] cpuAddr;
  logic        cpuWrite;
  logic [7:0]  cpuData_IN;
  logic [7:0]  busData_IN;
  logic        cpuHalt;
  logic [15:0] dmaAddr;
  logic        dmaReadWrite;
  logic [7:0]  dmaData_OUT;
  logic        oamData_EN;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  oam_dma_controller dut (
    .clk         (clk),
    .rst         (rst),
    .clkEn       (clkEn),
    .cpuAddr     (cpuAddr),
    .cpuWrite    (cpuWrite),
    .cpuData_IN  (cpuData_IN),
    .busData_IN  (busData_IN),
    .cpuHalt     (cpuHalt),
    .dmaAddr     (dmaAddr),
    .dmaReadWrite(dmaReadWrite),
    .dmaData_OUT (dmaData_OUT),
    .oamData_EN  (oamData_EN),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // CPU cycle = 3 clk; clkEn is a one-clk pulse, suppressible by clken_hold.
  int div = 0;
  bit clken_hold = 1'b0;
  always @(posedge clk) begin
    #1;
    div   = (div == 2) ? 0 : div + 1;
    clkEn = (div == 0) && !clken_hold;
  end

  // Memory: page $02 returns the low address byte, any other page its inverse.
  assign busData_IN = (dmaAddr[15:8] == 8'h02) ? dmaAddr[7:0] : ~dmaAddr[7:0];

  // Completed CPU cycles since reset; bit 0 is the parity of the current cycle.
  int cyc_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt <= 0;
    else if (clkEn) cyc_cnt <= cyc_cnt + 1;
  end

  // Per-CPU-cycle monitor, sampled mid-cycle.
  int        halt_cycles, wr_count, rd_count, wr_err, rd_err, bad_page, ctrl_err;
  logic [7:0]  wr_data [256];
  logic [15:0] first_read;
  bit          seen_read;

  always @(negedge clk) begin
    if (!rst && clkEn) begin
      if (cpuHalt) halt_cycles++;
      if (busy !== cpuHalt) ctrl_err++;
      if (oamData_EN) begin
        if (dmaAddr !== 16'h2004 || dmaReadWrite !== 1'b0) wr_err++;
        if (wr_count < 256) wr_data[wr_count] = dmaData_OUT;
        wr_count++;
      end else if (cpuHalt && dmaAddr != 16'h0000) begin
        if (dmaReadWrite !== 1'b1) rd_err++;
        if (dmaAddr[7:0] != rd_count[7:0]) rd_err++;
        if (dmaAddr[15:8] != 8'h02) bad_page++;
        if (!seen_read) first_read = dmaAddr;
        seen_read = 1'b1;
        rd_count++;
      end
    end
  end

  task automatic clear_stats();
    @(posedge clk);
    #2;
    halt_cycles = 0; wr_count = 0; rd_count = 0; wr_err = 0; rd_err = 0;
    bad_page = 0; ctrl_err = 0; seen_read = 1'b0; first_read = 16'hFFFF;
    for (int i = 0; i < 256; i++) wr_data[i] = 8'hXX;
  endtask

  // Present a CPU write to $4014 for exactly one CPU cycle; want_par < 0 means any parity.
  task automatic trigger_write(input logic [7:0] page, input int want_par);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (clkEn && (want_par < 0 || cyc_cnt[0] == want_par[0])) break;
    end
    cpuWrite   = 1'b1;
    cpuAddr    = 16'h4014;
    cpuData_IN = page;
    @(negedge clk);
    cpuWrite   = 1'b0;
    cpuAddr    = 16'h0000;
    cpuData_IN = 8'h00;
  endtask

  task automatic wait_done(input string name);
    bit saw, ok;
    saw = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #2;
      if (busy) saw = 1'b1;
      else if (saw) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done: transfer completed=%b, expected 1 within budget", name, ok);
    end
  endtask

  task automatic check_idle(input string name);
    logic [26:0] got;
    got = {cpuHalt, busy, oamData_EN, dmaReadWrite, dmaAddr, dmaData_OUT};
    n_cmp++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00}) begin
      n_bad++;
      $display("FAIL %s_idle: halt/busy/oam/rw/addr/data = %h, expected %h",
               name, got, {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00});
    end
  endtask

  task automatic check_transfer(input string name, input int exp_halt, input int exp_writes);
    int bad_data;
    bad_data = 0;
    for (int i = 0; i < exp_writes && i < 256; i++)
      if (wr_data[i] !== i[7:0]) bad_data++;
    n_cmp++;
    if (halt_cycles != exp_halt) begin
      n_bad++;
      $display("FAIL %s_stall: cpuHalt cycles %0d, expected %0d", name, halt_cycles, exp_halt);
    end
    n_cmp++;
    if (wr_count != exp_writes) begin
      n_bad++;
      $display("FAIL %s_writes: oamData_EN cycles %0d, expected %0d", name, wr_count, exp_writes);
    end
    n_cmp++;
    if (bad_data != 0) begin
      n_bad++;
      $display("FAIL %s_data: %0d bytes out of order, expected 0", name, bad_data);
    end
    n_cmp++;
    if (wr_err + rd_err + ctrl_err != 0) begin
      n_bad++;
      $display("FAIL %s_bus: write/read/ctrl errors %0d/%0d/%0d, expected 0/0/0",
               name, wr_err, rd_err, ctrl_err);
    end
    n_cmp++;
    if (first_read !== 16'h0200) begin
      n_bad++;
      $display("FAIL %s_first_read: address %h, expected 0200", name, first_read);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_idle("reset");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (60) @(posedge clk);
    #2;
    check_idle("post_reset");
    n_cmp++;
    if (halt_cycles != 0) begin
      n_bad++;
      $display("FAIL post_reset_no_dma: halt cycles %0d, expected 0", halt_cycles);
    end
  endtask

  task automatic test_even_alignment();
    clear_stats();
    trigger_write(8'h02, 0);
    wait_done("even");
    check_transfer("even", 513, 256);
    check_idle("even_end");
  endtask

  task automatic test_odd_alignment();
    clear_stats();
    trigger_write(8'h02, 1);
    wait_done("odd");
    check_transfer("odd", 514, 256);
  endtask

  task automatic test_ignore_retrigger();
    clear_stats();
    trigger_write(8'h02, 0);
    repeat (150) @(posedge clk);
    trigger_write(8'h07, -1);
    wait_done("retrig");
    check_transfer("retrig", 513, 256);
    n_cmp++;
    if (bad_page != 0) begin
      n_bad++;
      $display("FAIL retrig_page: %0d reads outside page 02, expected 0", bad_page);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int h;
    logic [2:0] got;
    clear_stats();
    trigger_write(8'h02, 0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      if (wr_count >= 100) break;
    end
    n_cmp++;
    if (cpuHalt !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_active: cpuHalt %b before reset, expected 1", cpuHalt);
    end
    rst = 1'b1;
    #1;
    got = {cpuHalt, busy, oamData_EN};
    n_cmp++;
    if (got !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_async: cpuHalt/busy/oamData_EN %b, expected 000", got);
    end
    check_idle("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    h = halt_cycles;
    repeat (1800) @(posedge clk);
    #2;
    n_cmp++;
    if (wr_count != 100) begin
      n_bad++;
      $display("FAIL midrst_writes: %0d strobes total, expected 100", wr_count);
    end
    n_cmp++;
    if (halt_cycles != h) begin
      n_bad++;
      $display("FAIL midrst_restart: %0d halt cycles after reset, expected 0", halt_cycles - h);
    end
  endtask

  task automatic test_clken_hold();
    logic [15:0] held_addr;
    int moved;
    clear_stats();
    trigger_write(8'h02, 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (dmaAddr == 16'h0280 && !clkEn) break;
    end
    clken_hold = 1'b1;
    held_addr  = dmaAddr;
    moved      = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dmaAddr !== 16'h0280 || cpuHalt !== 1'b1 || oamData_EN !== 1'b0 || clkEn) moved++;
    end
    clken_hold = 1'b0;
    n_cmp++;
    if (held_addr !== 16'h0280) begin
      n_bad++;
      $display("FAIL hold_reached: address %h, expected 0280", held_addr);
    end
    n_cmp++;
    if (moved != 0) begin
      n_bad++;
      $display("FAIL hold_stable: %0d clk with changed outputs, expected 0", moved);
    end
    wait_done("hold");
    check_transfer("hold", 513, 256);
  endtask

  initial begin
    rst        = 1'b1;
    cpuAddr    = 16'h0000;
    cpuWrite   = 1'b0;
    cpuData_IN = 8'h00;
    test_reset();
    test_even_alignment();
    test_odd_alignment();
    test_ignore_retrigger();
    test_reset_mid_transfer();
    test_clken_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
